// File: rtl/id_ex_ctrl_pipe_pkg.sv
// rtl/id_ex_ctrl_pipe_pkg.sv - shared opcode, encoding and control-bundle definitions
// Purpose: opcode[6:2] values, WB/IMM/ALU select encodings, the M-extension
//          funct7 value and the packed control bundle passed from decode to ID/EX.
// Ports:   none (package).
package id_ex_ctrl_pipe_pkg;

  localparam logic [4:0] OPC_R     = 5'b01100;
  localparam logic [4:0] OPC_I     = 5'b00100;
  localparam logic [4:0] OPC_LD    = 5'b00000;
  localparam logic [4:0] OPC_JALR  = 5'b11001;
  localparam logic [4:0] OPC_ST    = 5'b01000;
  localparam logic [4:0] OPC_BR    = 5'b11000;
  localparam logic [4:0] OPC_JAL   = 5'b11011;
  localparam logic [4:0] OPC_LUI   = 5'b01101;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] ALU_R   = 2'b00;
  localparam logic [1:0] ALU_I   = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic       reg_wen;
    logic       asel;
    logic       bsel;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       jump;
    logic [1:0] wb_sel;
    logic [2:0] imm_sel;
    logic [1:0] alu_op;
    logic       md;
    logic       md_div;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/id_ex_ctrl_pipe_dec.sv
// rtl/id_ex_ctrl_pipe_dec.sv - combinational instruction decode table
// Purpose: maps opcode/funct fields to the control bundle and register-use flags.
// Ports:   opc (instr[6:2]), funct3_msb (instr[14]), funct7 (instr[31:25]),
//          rd_zero (destination is x0) in; ctrl bundle, use_rs1, use_rs2 out.
module dec_ctrl_comb
  import id_ex_ctrl_pipe_pkg::*;
#(
  parameter int EN_M = 1
) (
  input  logic [4:0] opc,
  input  logic       funct3_msb,
  input  logic [6:0] funct7,
  input  logic       rd_zero,
  output ctrl_t      ctrl,
  output logic       use_rs1,
  output logic       use_rs2
);

  always_comb begin
    ctrl    = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      OPC_R: begin
        ctrl.reg_wen = 1'b1; ctrl.wb_sel = WB_ALU; ctrl.alu_op = ALU_R;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_I: begin
        ctrl.reg_wen = 1'b1; ctrl.bsel = 1'b1; ctrl.wb_sel = WB_ALU;
        ctrl.imm_sel = IMM_I; ctrl.alu_op = ALU_I; use_rs1 = 1'b1;
      end
      OPC_LD: begin
        ctrl.reg_wen = 1'b1; ctrl.bsel = 1'b1; ctrl.mem_read = 1'b1;
        ctrl.wb_sel = WB_MEM; ctrl.alu_op = ALU_ADD; use_rs1 = 1'b1;
      end
      OPC_JALR: begin
        ctrl.reg_wen = 1'b1; ctrl.bsel = 1'b1; ctrl.jump = 1'b1;
        ctrl.wb_sel = WB_PC4; ctrl.alu_op = ALU_ADD; use_rs1 = 1'b1;
      end
      OPC_ST: begin
        ctrl.mem_write = 1'b1; ctrl.bsel = 1'b1; ctrl.imm_sel = IMM_S;
        ctrl.alu_op = ALU_ADD; use_rs1 = 1'b1;
      end
      OPC_BR: begin
        ctrl.asel = 1'b1; ctrl.bsel = 1'b1; ctrl.branch = 1'b1;
        ctrl.imm_sel = IMM_B; ctrl.alu_op = ALU_ADD;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_JAL: begin
        ctrl.reg_wen = 1'b1; ctrl.asel = 1'b1; ctrl.bsel = 1'b1; ctrl.jump = 1'b1;
        ctrl.wb_sel = WB_PC4; ctrl.imm_sel = IMM_J; ctrl.alu_op = ALU_ADD;
      end
      OPC_LUI: begin
        ctrl.reg_wen = 1'b1; ctrl.wb_sel = WB_IMM; ctrl.imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.reg_wen = 1'b1; ctrl.asel = 1'b1; ctrl.bsel = 1'b1;
        ctrl.wb_sel = WB_ALU; ctrl.imm_sel = IMM_U; ctrl.alu_op = ALU_ADD;
      end
      default: ctrl.illegal = 1'b1;
    endcase

    // With EN_M = 0 the MULDIV encodings fall through as ordinary R-type.
    ctrl.md     = (EN_M != 0) && (opc == OPC_R) && (funct7 == FUNCT7_MULDIV);
    ctrl.md_div = ctrl.md & funct3_msb;

    // Writes to x0 are architecturally discarded; drop the enable here.
    if (rd_zero) ctrl.reg_wen = 1'b0;
  end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// rtl/id_ex_ctrl_pipe.sv - ID/EX control pipeline register with hazard and divide stall
// Purpose: registers the decoded control bundle into ID/EX, detects load-use hazards,
//          applies branch/jump flush and holds EX for multi-cycle divides.
// Ports:   clk, rst_n (sync active-low), id_valid, id_instr[31:0], flush in;
//          stall_id (combinational) and the registered ex_* control bundle out.
module id_ex_ctrl_pipe
  import id_ex_ctrl_pipe_pkg::*;
#(
  parameter int EN_M    = 1,
  parameter int DIV_LAT = 32,
  parameter int RA_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic            flush,
  output logic            stall_id,
  output logic            ex_valid,
  output logic            ex_reg_wen,
  output logic            ex_asel,
  output logic            ex_bsel,
  output logic            ex_mem_write,
  output logic            ex_mem_read,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic [1:0]      ex_wb_sel,
  output logic [2:0]      ex_imm_sel,
  output logic [1:0]      ex_alu_op,
  output logic            ex_md_op,
  output logic            ex_md_div,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_illegal
);

  localparam int CNT_W = $clog2(DIV_LAT);

  ctrl_t           dec;
  ctrl_t           ex_c;
  logic            use_rs1, use_rs2;
  logic [RA_W-1:0] rd, rs1, rs2;
  logic [CNT_W-1:0] cnt;
  logic            lu, db;
  logic            unused_bits;

  assign rd  = id_instr[7 +: RA_W];
  assign rs1 = id_instr[15 +: RA_W];
  assign rs2 = id_instr[20 +: RA_W];
  assign unused_bits = ^{id_instr[1:0], id_instr[13:12]};

  dec_ctrl_comb #(.EN_M(EN_M)) u_dec (
    .opc        (id_instr[6:2]),
    .funct3_msb (id_instr[14]),
    .funct7     (id_instr[31:25]),
    .rd_zero    (rd == '0),
    .ctrl       (dec),
    .use_rs1    (use_rs1),
    .use_rs2    (use_rs2)
  );

  assign lu = ex_valid & ex_c.mem_read & (ex_rd != '0) & id_valid &
              ((use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd)));
  assign db = (cnt != '0);
  assign stall_id = ~flush & (db | lu);

  // Priority: reset, flush, divide hold, load-use bubble, normal load.
  // A load-use seen while the divide holds EX is re-evaluated once db drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_c     <= '0;
      ex_rd    <= '0;
      cnt      <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_c     <= '0;
      ex_rd    <= '0;
      cnt      <= '0;
    end else if (db) begin
      cnt <= cnt - 1'b1;
    end else if (lu) begin
      ex_valid <= 1'b0;
      ex_c     <= '0;
      ex_rd    <= '0;
    end else begin
      ex_valid <= id_valid;
      ex_c     <= id_valid ? dec : '0;
      ex_rd    <= id_valid ? rd : '0;
      // Issue edge counts as the first of DIV_LAT cycles in EX.
      if (id_valid && dec.md_div) cnt <= CNT_W'(DIV_LAT - 1);
    end
  end

  assign ex_reg_wen   = ex_c.reg_wen;
  assign ex_asel      = ex_c.asel;
  assign ex_bsel      = ex_c.bsel;
  assign ex_mem_write = ex_c.mem_write;
  assign ex_mem_read  = ex_c.mem_read;
  assign ex_branch    = ex_c.branch;
  assign ex_jump      = ex_c.jump;
  assign ex_wb_sel    = ex_c.wb_sel;
  assign ex_imm_sel   = ex_c.imm_sel;
  assign ex_alu_op    = ex_c.alu_op;
  assign ex_md_op     = ex_c.md;
  assign ex_md_div    = ex_c.md_div;
  assign ex_illegal   = ex_c.illegal;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// tb/tb_id_ex_ctrl_pipe.sv - directed self-checking bench for id_ex_ctrl_pipe
module tb_id_ex_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, flush;
  logic [31:0] id_instr;

  logic        a_stall, a_valid, a_wen, a_asel, a_bsel, a_mw, a_mr, a_br, a_j, a_md, a_mdd, a_ill;
  logic [1:0]  a_wb, a_alu;
  logic [2:0]  a_imm;
  logic [4:0]  a_rd;
  logic        b_stall, b_valid, b_wen, b_asel, b_bsel, b_mw, b_mr, b_br, b_j, b_md, b_mdd, b_ill;
  logic [1:0]  b_wb, b_alu;
  logic [2:0]  b_imm;
  logic [4:0]  b_rd;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  id_ex_ctrl_pipe #(.EN_M(1), .DIV_LAT(4), .RA_W(5)) u_m (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .flush(flush),
    .stall_id(a_stall), .ex_valid(a_valid), .ex_reg_wen(a_wen), .ex_asel(a_asel),
    .ex_bsel(a_bsel), .ex_mem_write(a_mw), .ex_mem_read(a_mr), .ex_branch(a_br),
    .ex_jump(a_j), .ex_wb_sel(a_wb), .ex_imm_sel(a_imm), .ex_alu_op(a_alu),
    .ex_md_op(a_md), .ex_md_div(a_mdd), .ex_rd(a_rd), .ex_illegal(a_ill)
  );

  id_ex_ctrl_pipe #(.EN_M(0), .DIV_LAT(4), .RA_W(5)) u_nom (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .flush(flush),
    .stall_id(b_stall), .ex_valid(b_valid), .ex_reg_wen(b_wen), .ex_asel(b_asel),
    .ex_bsel(b_bsel), .ex_mem_write(b_mw), .ex_mem_read(b_mr), .ex_branch(b_br),
    .ex_jump(b_j), .ex_wb_sel(b_wb), .ex_imm_sel(b_imm), .ex_alu_op(b_alu),
    .ex_md_op(b_md), .ex_md_div(b_mdd), .ex_rd(b_rd), .ex_illegal(b_ill)
  );

  wire [16:0] a_ctl = {a_wen, a_asel, a_bsel, a_mw, a_mr, a_br, a_j, a_wb, a_imm, a_alu, a_md, a_mdd, a_ill};
  wire [16:0] b_ctl = {b_wen, b_asel, b_bsel, b_mw, b_mr, b_br, b_j, b_wb, b_imm, b_alu, b_md, b_mdd, b_ill};

  // Expected bundle: wen asel bsel mw mr br j wb imm alu md mdd ill
  function automatic logic [16:0] mk(input logic wen, asel, bsel, mw, mr, br, j,
                                     input logic [1:0] wb, input logic [2:0] imm,
                                     input logic [1:0] alu, input logic md, mdd, ill);
    return {wen, asel, bsel, mw, mr, br, j, wb, imm, alu, md, mdd, ill};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] i_add, i_lw, i_sw, i_div, i_mul, i_ill, i_addi0, i_jal;
  logic [16:0] c_r, c_ld, c_st;

  initial begin
    i_add   = rtype(7'b0000000, 5'd1, 5'd5, 3'b000, 5'd6, 7'b0110011);
    i_lw    = {12'd0, 5'd2, 3'b010, 5'd5, 7'b0000011};
    i_sw    = rtype(7'b0000000, 5'd5, 5'd2, 3'b010, 5'd0, 7'b0100011);
    i_div   = rtype(7'b0000001, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0110011);
    i_mul   = rtype(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
    i_ill   = {25'd0, 7'b1111111};
    i_addi0 = {12'd5, 5'd1, 3'b000, 5'd0, 7'b0010011};
    i_jal   = {20'd0, 5'd1, 7'b1101111};
    c_r     = mk(1,0,0,0,0,0,0,2'b01,3'b000,2'b00,0,0,0);
    c_ld    = mk(1,0,1,0,1,0,0,2'b00,3'b000,2'b10,0,0,0);
    c_st    = mk(0,0,1,1,0,0,0,2'b00,3'b001,2'b10,0,0,0);

    // Reset with a live ADD at the input
    rst_n = 1'b0; id_valid = 1'b1; flush = 1'b0; id_instr = i_add;
    tick; tick;
    chk("rst_ctl", {15'd0, a_ctl}, 32'd0);
    chk("rst_valid_rd", {26'd0, a_valid, a_rd}, 32'd0);
    chk("rst_stall", {31'd0, a_stall}, 32'd0);
    rst_n = 1'b1;
    tick;
    chk("add_valid", {31'd0, a_valid}, 32'd1);
    chk("add_ctl", {15'd0, a_ctl}, {15'd0, c_r});
    chk("add_rd", {27'd0, a_rd}, 32'd6);

    // Load-use: LW x5 then ADD x6,x5,x1
    id_instr = i_lw;
    tick;
    chk("lw_ctl", {15'd0, a_ctl}, {15'd0, c_ld});
    id_instr = i_add; #1;
    chk("lu_stall", {31'd0, a_stall}, 32'd1);
    tick;
    chk("lu_bubble", {31'd0, a_valid}, 32'd0);
    chk("lu_bubble_ctl", {15'd0, a_ctl}, 32'd0);
    chk("lu_stall_clr", {31'd0, a_stall}, 32'd0);
    tick;
    chk("lu_add_in", {26'd0, a_valid, a_rd}, {26'd0, 1'b1, 5'd6});

    // LW x5 then SW x5,0(x2): rs2 not treated as used, no stall
    id_instr = i_lw;
    tick;
    id_instr = i_sw; #1;
    chk("sw_nostall", {31'd0, a_stall}, 32'd0);
    tick;
    chk("sw_ctl", {15'd0, a_ctl}, {15'd0, c_st});
    chk("sw_valid", {31'd0, a_valid}, 32'd1);

    // Divide, DIV_LAT = 4: four cycles in EX, three stall cycles
    id_instr = i_div;
    tick;
    chk("div_ctl", {15'd0, a_ctl}, {15'd0, mk(1,0,0,0,0,0,0,2'b01,3'b000,2'b00,1,1,0)});
    id_instr = i_add; #1;
    chk("div_stall0", {31'd0, a_stall}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick;
      chk($sformatf("div_hold%0d", k), {31'd0, a_mdd}, 32'd1);
      chk($sformatf("div_stall%0d", k), {31'd0, a_stall}, (k < 3) ? 32'd1 : 32'd0);
    end
    tick;
    chk("div_next_in", {25'd0, a_valid, a_mdd, a_rd}, {25'd0, 1'b1, 1'b0, 5'd6});

    // Flush on the second busy cycle aborts the divide
    id_instr = i_div;
    tick;
    id_instr = i_add;
    tick;
    chk("fdiv_busy", {31'd0, a_stall}, 32'd1);
    flush = 1'b1; #1;
    chk("fdiv_stall_flush", {31'd0, a_stall}, 32'd0);
    tick;
    chk("fdiv_killed", {30'd0, a_valid, a_mdd}, 32'd0);
    flush = 1'b0; #1;
    chk("fdiv_cnt_zero", {31'd0, a_stall}, 32'd0);
    tick;
    chk("fdiv_add_in", {26'd0, a_valid, a_rd}, {26'd0, 1'b1, 5'd6});

    // Flush coinciding with a load-use hazard
    id_instr = i_lw;
    tick;
    id_instr = i_add; flush = 1'b1; #1;
    chk("flush_lu_stall", {31'd0, a_stall}, 32'd0);
    tick;
    chk("flush_lu_valid", {31'd0, a_valid}, 32'd0);
    flush = 1'b0;

    // id_valid low loads a zeroed entry
    id_valid = 1'b0; id_instr = i_add;
    tick;
    chk("novalid", {14'd0, a_valid, a_ctl}, 32'd0);
    id_valid = 1'b1;

    // MUL: EN_M = 0 decodes plain R-type, EN_M = 1 flags md_op
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1; id_instr = i_mul;
    tick;
    chk("nom_mul_ctl", {15'd0, b_ctl}, {15'd0, c_r});
    chk("nom_mul_stall", {30'd0, b_valid, b_stall}, 32'd2);
    chk("m_mul_ctl", {15'd0, a_ctl}, {15'd0, mk(1,0,0,0,0,0,0,2'b01,3'b000,2'b00,1,0,0)});
    chk("m_mul_stall", {31'd0, a_stall}, 32'd0);

    // Illegal opcode, ADDI to x0, JAL
    id_instr = i_ill;
    tick;
    chk("ill_ctl", {15'd0, a_ctl}, 32'd1);
    chk("ill_valid", {31'd0, a_valid}, 32'd1);
    id_instr = i_addi0;
    tick;
    chk("addi_x0", {15'd0, a_ctl}, {15'd0, mk(0,0,1,0,0,0,0,2'b01,3'b000,2'b01,0,0,0)});
    id_instr = i_jal;
    tick;
    chk("jal_ctl", {15'd0, a_ctl}, {15'd0, mk(1,1,1,0,0,0,1,2'b10,3'b100,2'b10,0,0,0)});
    chk("jal_rd", {27'd0, a_rd}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
